// File: rtl/twi_fan_ctrl_if.sv
// Wishbone master-side bus between the fan controller and the TWI register slave.
// The controller owns CYC/STB/WE/ADR/DAT/SEL; the slave returns ACK and read data.
interface twi_fan_ctrl_if;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [5:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/twi_fan_ctrl.sv
// Closed-loop fan controller: every PERIOD_CNT cycles reads FAN0, steps duty toward TGT_I, writes PWMC.
// One iteration is 5 cycles with a 1-cycle ACK; waits on ACK up to ACK_TO cycles. Stall fault: FAN_CTRL_FAULT_EN.
module twi_fan_ctrl #(
  parameter int          PERIOD_CNT = 50_000_000,
  parameter logic [9:0]  STEP       = 10'd8,
  parameter logic [26:0] HYST       = 27'd2,
  parameter logic [9:0]  PWM_MIN    = 10'd64,
  parameter logic [9:0]  PWM_MAX    = 10'd1023,
  parameter logic [5:0]  ADR_FAN0   = 6'h18,
  parameter logic [5:0]  ADR_PWMC   = 6'h0C,
  parameter int          ACK_TO     = 15,
  parameter int          FAULT_CNT  = 3
) (
  input  logic          CLK_I,
  input  logic          RST_N,
  input  logic          EN_I,
  input  logic [26:0]   TGT_I,
  twi_fan_ctrl_if.master m,
  output logic [9:0]    PWM_O,
  output logic          BUSY_O,
  output logic          BUS_ERR_O,
  output logic          FAULT_O
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_CALC = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;

  localparam int TMAX = (PERIOD_CNT > ACK_TO) ? PERIOD_CNT : ACK_TO;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PER_LAST = TW'(PERIOD_CNT - 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TO - 1);

  logic [2:0]    state_q, state_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [5:0]    adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [26:0]   speed_q, speed_d;
  logic [9:0]    duty_q, duty_d;
  logic          err_q, err_d;

  // Compare in 28 bits and step duty in 11 bits so neither side can wrap.
  logic        too_slow, too_fast;
  logic [10:0] duty_inc, duty_dec_lim;
  logic [9:0]  duty_up, duty_dn;

  assign too_slow     = ({1'b0, speed_q} + {1'b0, HYST}) < {1'b0, TGT_I};
  assign too_fast     = {1'b0, speed_q} > ({1'b0, TGT_I} + {1'b0, HYST});
  assign duty_inc     = {1'b0, duty_q} + {1'b0, STEP};
  assign duty_dec_lim = {1'b0, PWM_MIN} + {1'b0, STEP};
  assign duty_up      = (duty_inc > {1'b0, PWM_MAX}) ? PWM_MAX : duty_inc[9:0];
  assign duty_dn      = ({1'b0, duty_q} < duty_dec_lim) ? PWM_MIN : (duty_q - STEP);

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tmr_d   = tmr_q;
    speed_d = speed_q;
    duty_d  = duty_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (EN_I) begin
          duty_d  = PWM_MAX;
          state_d = S_INIT;
        end
      end
      S_INIT, S_RD, S_WR: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = (state_q != S_RD);
          adr_d = (state_q == S_RD) ? ADR_FAN0 : ADR_PWMC;
          dat_d = {22'b0, duty_q};
          tmr_d = '0;
        end else if (m.m_ack_i) begin
          stb_d = 1'b0;
          we_d  = 1'b0;
          tmr_d = '0;
          if (state_q == S_RD) speed_d = m.m_dat_i[26:0];
          if (!EN_I)                state_d = S_IDLE;
          else if (state_q == S_RD) state_d = S_CALC;
          else                      state_d = S_WAIT;
        end else if (tmr_q == ACK_LAST) begin
          // Abandon the cycle; duty is untouched and the loop retries next period.
          stb_d   = 1'b0;
          we_d    = 1'b0;
          tmr_d   = '0;
          err_d   = 1'b1;
          state_d = EN_I ? S_WAIT : S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_WAIT: begin
        if (!EN_I) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else if (tmr_q == PER_LAST) begin
          tmr_d   = '0;
          state_d = S_RD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CALC: begin
        if (too_slow)      duty_d = duty_up;
        else if (too_fast) duty_d = duty_dn;
        state_d = S_WR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmr_q   <= '0;
      speed_q <= '0;
      duty_q  <= PWM_MAX;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tmr_q   <= tmr_d;
      speed_q <= speed_d;
      duty_q  <= duty_d;
      err_q   <= err_d;
    end
  end

  assign m.m_cyc_o = stb_q;
  assign m.m_stb_o = stb_q;
  assign m.m_we_o  = we_q;
  assign m.m_adr_o = adr_q;
  assign m.m_dat_o = dat_q;
  assign m.m_sel_o = 4'hF;

  assign PWM_O     = duty_q;
  assign BUSY_O    = (state_q == S_RD) || (state_q == S_CALC) || (state_q == S_WR);
  assign BUS_ERR_O = err_q;

  logic unused_dat_hi;
  assign unused_dat_hi = ^m.m_dat_i[31:27];

`ifdef FAN_CTRL_FAULT_EN
  localparam int SW = $clog2(FAULT_CNT + 1);
  localparam logic [SW-1:0] STALL_SAT  = SW'(FAULT_CNT);
  localparam logic [SW-1:0] STALL_LAST = SW'(FAULT_CNT - 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          fault_q, fault_d;

  // A stall is a zero tach reading while already driving full duty.
  always_comb begin
    stall_d = stall_q;
    fault_d = fault_q;
    if (state_q == S_IDLE && !EN_I) begin
      stall_d = '0;
      fault_d = 1'b0;
    end else if (state_q == S_CALC) begin
      if (speed_q == 27'd0 && duty_q == PWM_MAX) begin
        if (stall_q < STALL_SAT)   stall_d = stall_q + SW'(1);
        if (stall_q >= STALL_LAST) fault_d = 1'b1;
      end else begin
        stall_d = '0;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
      fault_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      fault_q <= fault_d;
    end
  end

  assign FAULT_O = fault_q;
`else
  logic unused_fault_cfg;
  assign unused_fault_cfg = ^FAULT_CNT;
  assign FAULT_O = 1'b0;
`endif

endmodule

// File: tb/tb_twi_fan_ctrl.sv
// Randomized scoreboard bench for twi_fan_ctrl: expected bus transactions are queued by a
// transaction-level loop model and popped by a monitor on every acknowledged strobe.
module tb_twi_fan_ctrl;
  localparam int PER = 8;
  localparam logic [5:0] A_FAN0 = 6'h18;
  localparam logic [5:0] A_PWMC = 6'h0C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [26:0] tgt = 27'd100;
  logic        ack_en = 1'b1;
  logic [31:0] rd_dat = 32'd0;
  logic [9:0]  pwm;
  logic        busy, bus_err, fault;

  twi_fan_ctrl_if bus();
  assign bus.m_ack_i = bus.m_stb_o & ack_en;
  assign bus.m_dat_i = rd_dat;

  twi_fan_ctrl #(.PERIOD_CNT(PER)) dut (
    .CLK_I(clk), .RST_N(rst_n), .EN_I(en), .TGT_I(tgt), .m(bus),
    .PWM_O(pwm), .BUSY_O(busy), .BUS_ERR_O(bus_err), .FAULT_O(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [5:0] adr;
    logic [9:0] duty;
    logic       fault;
    logic       busy;
  } txn_t;

  txn_t exp_q[$];
  int checks = 0, failures = 0;
  int txn_cnt = 0, exp_total = 0, err_cnt = 0, stb_run = 0;
  int m_duty = 1023, m_stall = 0;
  bit m_fault = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Loop behaviour expressed as plain integer arithmetic on the tach reading.
  task automatic model_iter(input int speed);
`ifdef FAN_CTRL_FAULT_EN
    if (speed == 0 && m_duty == 1023) m_stall++; else m_stall = 0;
    if (m_stall >= 3) m_fault = 1'b1;
`endif
    if (speed + 2 < int'(tgt))      m_duty = (m_duty + 8 > 1023) ? 1023 : m_duty + 8;
    else if (speed > int'(tgt) + 2) m_duty = (m_duty - 8 < 64) ? 64 : m_duty - 8;
  endtask

  task automatic push(input logic we, input logic [5:0] adr, input logic busy_exp);
    txn_t t;
    t.we = we; t.adr = adr; t.duty = 10'(m_duty); t.fault = m_fault; t.busy = busy_exp;
    exp_q.push_back(t);
    exp_total++;
  endtask

  task automatic queue_iter(input int speed);
    rd_dat = {5'($urandom), 27'(speed)};
    push(1'b0, A_FAN0, 1'b1);
    model_iter(speed);
    push(1'b1, A_PWMC, 1'b1);
  endtask

  task automatic wait_txn(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (txn_cnt >= exp_total) done = 1'b1;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic do_iter(input int speed);
    queue_iter(speed);
    wait_txn("iter_done");
  endtask

  // Monitor: every acknowledged strobe must match the head of the expected queue.
  always @(negedge clk) begin
    txn_t e;
    if (rst_n) begin
      chk("cyc_eq_stb", bus.m_cyc_o, bus.m_stb_o);
      if (bus_err) err_cnt++;
      if (bus.m_stb_o && bus.m_ack_i) begin
        stb_run = 0;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_txn actual adr=%0h we=%0b required none", bus.m_adr_o, bus.m_we_o);
        end else begin
          e = exp_q.pop_front();
          chk("bus_we", bus.m_we_o, e.we);
          chk("bus_adr", bus.m_adr_o, e.adr);
          chk("bus_sel", bus.m_sel_o, 4'hF);
          chk("busy", busy, e.busy);
          if (e.we) begin
            chk("bus_dat", bus.m_dat_o, {22'b0, e.duty});
            chk("pwm", pwm, e.duty);
            chk("fault", fault, e.fault);
          end
        end
        txn_cnt++;
      end else if (bus.m_stb_o) begin
        stb_run++;
      end else if (stb_run != 0) begin
        chk("ack_timeout_len", stb_run, 15);
        stb_run = 0;
      end
    end
  end

  initial begin
    int cnt, base, stb_seen;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_stb", bus.m_stb_o, 1'b0);
    chk("rst_cyc", bus.m_cyc_o, 1'b0);
    chk("rst_we", bus.m_we_o, 1'b0);
    chk("rst_adr", bus.m_adr_o, 6'h0);
    chk("rst_dat", bus.m_dat_o, 32'h0);
    chk("rst_pwm", pwm, 10'd1023);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_fault", fault, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_stb", bus.m_stb_o, 1'b0);

    // Enable: INIT writes full duty, strobe two clocks after EN_I.
    m_duty = 1023;
    push(1'b1, A_PWMC, 1'b0);
    en = 1'b1;
    cnt = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.m_stb_o) begin cnt = i; seen = 1'b1; end
    end
    chk("en_to_stb", cnt, 2);
    wait_txn("init_done");

    // Stalled fan at full duty, then slowdown to the floor, then back to the ceiling.
    repeat (4) do_iter(0);
    repeat (125) do_iter(200);
    chk("floor_pwm", pwm, 10'd64);
    repeat (122) do_iter(50);
    chk("ceil_pwm", pwm, 10'd1023);
    repeat (125) do_iter(200);
    for (int i = 0; i < 9; i++) do_iter(99 + (i % 3));
    for (int i = 0; i < 40; i++) begin
      tgt = 27'($urandom_range(0, 400));
      do_iter((i % 7 == 0) ? 0 : int'($urandom_range(0, 400)));
    end

    // Read that is never acknowledged.
    tgt = 27'd100;
    ack_en = 1'b0;
    base = err_cnt;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus_err) seen = 1'b1;
    end
    chk("err_seen", seen, 1'b1);
    ack_en = 1'b1;
    chk("err_pwm_hold", pwm, 10'(m_duty));
    queue_iter(int'($urandom_range(0, 300)));
    cnt = 0; seen = 1'b0;
    for (int i = 1; i <= 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.m_stb_o) begin cnt = i; seen = 1'b1; end
    end
    chk("retry_gap_ok", (cnt >= PER && cnt <= PER + 2), 1'b1);
    wait_txn("retry_done");
    chk("err_pulses", err_cnt - base, 1);

    // Drop EN_I during the write strobe.
    queue_iter(200);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.m_stb_o && bus.m_we_o) seen = 1'b1;
    end
    chk("wr_strobe_seen", seen, 1'b1);
    en = 1'b0;
    wait_txn("disable_done");
    stb_seen = 0;
    repeat (2 * PER + 4) begin
      @(negedge clk);
      if (bus.m_stb_o || busy) stb_seen++;
    end
    chk("idle_quiet", stb_seen, 0);
    m_fault = 1'b0; m_stall = 0;
    chk("fault_clear", fault, 1'b0);
    chk("idle_pwm_hold", pwm, 10'(m_duty));

    // Re-enable restarts from full duty.
    m_duty = 1023;
    push(1'b1, A_PWMC, 1'b0);
    en = 1'b1;
    wait_txn("reinit_done");
    repeat (3) do_iter(0);
    repeat (3) do_iter(int'($urandom_range(0, 300)));

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
